// File: rtl/dlatch_pkg.sv
// Shared definitions for the D-latch checker.
//   chk_state_t : checker FSM states (encoding 3 unused, recovers to UNINIT)
//   SYNC_STAGES : depth of each input synchronizer
//   SETTLE_W    : width of the settle counter (SETTLE_CYCLES up to 15)
package dlatch_pkg;

  typedef enum logic [1:0] {
    UNINIT = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } chk_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int SETTLE_W    = 4;

endpackage

// File: rtl/sync2.sv
// Single-bit multi-flop synchronizer (SYNC_STAGES deep, normally 2).
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   din   - asynchronous input
//   dout  - synchronized output
module sync2
  import dlatch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] ff_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_reg <= '0;
    end else begin
      ff_reg <= {ff_reg[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = ff_reg[SYNC_STAGES-1];

endmodule

// File: rtl/dlatch_checker.sv
// Self-checking observer for a level-sensitive D latch. It synchronizes the
// latch stimulus and outputs, keeps a reference latch model, waits for the
// inputs to settle and then compares the latch outputs every cycle.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   d, en               - latch stimulus (asynchronous)
//   q, q_bar            - latch outputs under check (asynchronous)
//   check_en            - comparisons are counted/reported only while high
//   clr                 - clears counters and sticky flag (wins over errors)
//   err_pulse           - one-cycle pulse per failing comparison
//   err_sticky          - set on any error until clr or reset
//   err_count/cmp_count - saturating failing/total comparison counts
//   state               - FSM state for debug
module dlatch_checker
  import dlatch_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic             en,
  input  logic             q,
  input  logic             q_bar,
  input  logic             check_en,
  input  logic             clr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cmp_count,
  output logic [1:0]       state
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  // ---------------------------------------------------------------------
  // Input synchronization: bit order {d, en, q, q_bar}
  // ---------------------------------------------------------------------
  logic [3:0] raw_in;
  logic [3:0] sync_out;
  logic       d_s, en_s, q_s, qb_s;

  assign raw_in = {d, en, q, q_bar};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (raw_in[gi]),
        .dout  (sync_out[gi])
      );
    end
  endgenerate

  assign {d_s, en_s, q_s, qb_s} = sync_out;

  // ---------------------------------------------------------------------
  // Reference model and change detection
  // ---------------------------------------------------------------------
  logic d_prev_reg, en_prev_reg, exp_q_reg;
  logic changed;

  // d only matters while the latch is transparent; with en low the latch
  // holds, so d movement must not restart the settle window.
  assign changed = (en_s != en_prev_reg) || (en_s && (d_s != d_prev_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev_reg  <= 1'b0;
      en_prev_reg <= 1'b0;
      exp_q_reg   <= 1'b0;
    end else begin
      d_prev_reg  <= d_s;
      en_prev_reg <= en_s;
      if (en_s) begin
        exp_q_reg <= d_s;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM and settle counter
  // ---------------------------------------------------------------------
  chk_state_t          state_reg, state_next;
  logic [SETTLE_W-1:0] cnt_reg, cnt_next;
  logic                do_cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= UNINIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    do_cmp     = 1'b0;
    case (state_reg)
      UNINIT: begin
        if (en_s) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (changed) begin
          cnt_next = SETTLE_LOAD;
        end else if (cnt_reg == '0) begin
          state_next = CHECK;
        end else begin
          cnt_next = cnt_reg - SETTLE_W'(1);
        end
      end
      CHECK: begin
        if (changed) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end else begin
          do_cmp = 1'b1;
        end
      end
      default: begin
        state_next = UNINIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Comparison, counters and output registers
  // ---------------------------------------------------------------------
  logic             cmp_valid, cmp_fail;
  logic             sticky_next;
  logic [CNT_W-1:0] err_count_next, cmp_count_next;
  logic             err_pulse_reg, err_sticky_reg;
  logic [CNT_W-1:0] err_count_reg, cmp_count_reg;

  assign cmp_valid = do_cmp && check_en;
  assign cmp_fail  = cmp_valid && ((q_s != exp_q_reg) || (q_s == qb_s));

  always_comb begin
    sticky_next    = err_sticky_reg;
    err_count_next = err_count_reg;
    cmp_count_next = cmp_count_reg;
    if (cmp_valid && (cmp_count_reg != CNT_MAX)) begin
      cmp_count_next = cmp_count_reg + CNT_W'(1);
    end
    if (cmp_fail) begin
      sticky_next = 1'b1;
      if (err_count_reg != CNT_MAX) begin
        err_count_next = err_count_reg + CNT_W'(1);
      end
    end
    // clr has priority over a same-cycle error; the pulse is unaffected.
    if (clr) begin
      sticky_next    = 1'b0;
      err_count_next = '0;
      cmp_count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_reg  <= 1'b0;
      err_sticky_reg <= 1'b0;
      err_count_reg  <= '0;
      cmp_count_reg  <= '0;
    end else begin
      err_pulse_reg  <= cmp_fail;
      err_sticky_reg <= sticky_next;
      err_count_reg  <= err_count_next;
      cmp_count_reg  <= cmp_count_next;
    end
  end

  assign err_pulse  = err_pulse_reg;
  assign err_sticky = err_sticky_reg;
  assign err_count  = err_count_reg;
  assign cmp_count  = cmp_count_reg;
  assign state      = state_reg;

endmodule

// File: doc/dlatch_checker.md
# dlatch_checker

Synchronous, self-checking observer for the level-sensitive D latch. It receives the same `d`/`en` stimulus the latch receives, plus the latch's `q`/`q_bar`. It keeps a reference model of the latch and reports mismatches and non-complementary outputs as error pulses and counters. It sits beside the latch in bench-level or on-chip self-test builds, so latch testbenches can check results instead of relying on printed traces.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: clock cycles the synchronized inputs must be stable before a comparison is made (range 1–15).
- `CNT_W`, default 8: width of the error and compare counters.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `d`  in  1: latch data input (asynchronous to `clk`).
- `en`  in  1: latch enable (asynchronous to `clk`).
- `q`  in  1: latch output under check (asynchronous).
- `q_bar`  in  1: latch complementary output (asynchronous).
- `check_en`  in  1: synchronous; comparisons count only while high.
- `clr`  in  1: synchronous; clears counters and the sticky flag.
- `err_pulse`  out  1: one-cycle pulse per failing comparison.
- `err_sticky`  out  1: set on the first error; held until `clr` or reset.
- `err_count`  out  CNT_W: failing comparisons, saturating.
- `cmp_count`  out  CNT_W: comparisons performed, saturating.
- `state`  out  2: FSM state encoding, for debug.

## Operation
- Synchronization:
  - `d`, `en`, `q` and `q_bar` each pass through a 2-flop synchronizer, giving `d_s`, `en_s`, `q_s` and `qb_s`.
  - All logic below uses only the synchronized values.
- Reference model:
  - `exp_q` takes `d_s` on every cycle where `en_s`=1; otherwise it holds.
  - `exp_q` is meaningless until the first cycle with `en_s`=1.
- FSM states:
  - UNINIT=0: no known latch value. No compares. Goes to SETTLE on the first cycle with `en_s`=1.
  - SETTLE=1: a counter is loaded with SETTLE_CYCLES−1 on entry and decrements each cycle. Goes to CHECK when the counter is 0 and the inputs are unchanged.
  - CHECK=2: compares every cycle.
  - Encoding 3 is unused; it recovers to UNINIT.
- Restart rule: in SETTLE or CHECK, a change in `en_s`, or a change in `d_s` while `en_s`=1, forces SETTLE and reloads the counter. A change in `d_s` while `en_s`=0 is ignored, because the latch is opaque.
- Comparison (CHECK and `check_en`=1 only):
  - The comparison fails if `q_s`≠`exp_q`, or if `q_s`==`qb_s`.
  - `cmp_count` increments on every comparison.
  - On a failure, `err_count` increments and `err_pulse` is asserted.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `clr` zeroes `err_count`, `cmp_count` and `err_sticky`. It does not disturb the FSM or `exp_q`.
- If `clr` and an error occur in the same cycle, `clr` wins: counters read 0 and no sticky is set. `err_pulse` is still emitted.
- Reset mid-operation: all synchronizer flops are cleared to 0 and the FSM returns to UNINIT. All outputs are held at their reset values while `rst_n`=0.

## Timing
- Reset values: `err_pulse`=0, `err_sticky`=0, `err_count`=0, `cmp_count`=0, `state`=UNINIT. `exp_q`=0.
- Synchronizer latency: 2 cycles, from a pin change to the synchronized value.
- First compare: for a stimulus change sampled at edge t, the first compare is evaluated in cycle t+2+SETTLE_CYCLES. `err_pulse` and the counters are registered and become visible one edge later.
- Pulse behaviour: `err_pulse` is high for exactly one cycle per failing compare. A persistent mismatch pulses every compare cycle.
- `check_en` low: the FSM and model continue to update; only counting and error reporting are suppressed.

## Structure
- Shared package `dlatch_pkg`:
  - FSM state enum `chk_state_t` (UNINIT, SETTLE, CHECK).
  - Constant `SYNC_STAGES`=2.
- Sub-module `sync2`: a single-bit two-flop synchronizer with `clk` and `rst_n`. It is instantiated four times.
- The top module holds the model, the FSM, the settle counter, the saturating counters and the output registers.

## Test plan
- Reset hold: assert `rst_n`=0 with random pins → all outputs 0 and `state`=0. Release, keep `en`=0 for 20 cycles → `cmp_count` stays 0.
- Correct latch:
  - Stimulus: `en`=1, `d`=1, `q`=1, `q_bar`=0, `check_en`=1, hold 10 cycles.
  - Response: `state` reaches CHECK at cycle 4 after the change, no `err_pulse`, and `cmp_count` increments once per cycle once CHECK is reached.
- Opaque hold:
  - Stimulus: `en`=0, toggle `d` 0/1 every 5 cycles while `q` holds its last value 1.
  - Response: state stays CHECK and `err_count`=0.
- Stuck output:
  - Stimulus: `en`=1, `d`=0, `q`=1 held.
  - Response: `err_pulse` every compare cycle, `err_sticky`=1, and `err_count` rises by 1 per cycle.
- Complement fault:
  - Stimulus: `q`=`q_bar`=1 with `exp_q`=1.
  - Response: error flagged. Then `clr` → `err_count`=0 and `err_sticky`=0.
- Saturation and reset: with `CNT_W`=4, force 20 errors → `err_count`=15. Assert `rst_n` mid-stream → all outputs 0 immediately.
